// File: rtl/pong_ball_engine.sv
// rtl/pong_ball_engine.sv - frame-ticked Pong ball physics, paddle collision, scoring and serve sequencing
module pong_ball_engine #(
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int POS_W         = 10,
    parameter int BALL_SIZE     = 10,
    parameter int PADDLE_LENGTH = 50,
    parameter int PADDLE_WIDTH  = 5,
    parameter int PADDLE_ONE_X  = 20,
    parameter int PADDLE_TWO_X  = 600,
    parameter int SPEED_MAX     = 4,
    parameter int SERVE_DELAY   = 60,
    parameter int WIN_SCORE     = 9
) (
    input  logic             clk50M,
    input  logic             reset_n,
    input  logic             endofframe,
    input  logic             restart,
    input  logic [POS_W-1:0] paddle_one_y,
    input  logic [POS_W-1:0] paddle_two_y,
    output logic [POS_W-1:0] ball_x,
    output logic [POS_W-1:0] ball_y,
    output logic [3:0]       score_one,
    output logic [3:0]       score_two,
    output logic             collided,
    output logic             missed,
    output logic             game_over
);

    // Two guard bits so position + size + speed sums never wrap.
    localparam int EW  = POS_W + 2;
    localparam int SPW = (SPEED_MAX < 2) ? 1 : $clog2(SPEED_MAX + 1);
    localparam int CW  = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY);

    localparam logic [POS_W-1:0] CX        = POS_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0] CY        = POS_W'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [SPW-1:0]   SPEED_ONE = SPW'(1);
    localparam logic [SPW-1:0]   SPEED_TOP = SPW'(SPEED_MAX);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(SERVE_DELAY - 1);
    localparam logic [3:0]       WIN       = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        SERVE,
        PLAY,
        OVER
    } state_t;

    state_t           state, state_nx;
    logic             endofframe_q;
    logic             tick;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [POS_W-1:0] bx_nx, by_nx;
    logic             dir_x, dir_y, dx_nx, dy_nx;
    logic [SPW-1:0]   speed, speed_nx, speed_inc;
    logic [3:0]       s1_nx, s2_nx;
    logic             col_nx, mis_nx;

    logic [EW-1:0]    bx_e, by_e, spd_e, p1_e, p2_e;
    logic             ov_one, ov_two;
    logic             hit_one, miss_one, hit_two, miss_two;
    logic             top_hit, bot_hit;
    logic [POS_W-1:0] y_mv;
    logic             dy_mv;

    assign tick      = endofframe & ~endofframe_q;
    assign game_over = (state == OVER);

    assign bx_e  = EW'(ball_x);
    assign by_e  = EW'(ball_y);
    assign spd_e = EW'(speed);
    assign p1_e  = EW'(paddle_one_y);
    assign p2_e  = EW'(paddle_two_y);

    assign ov_one = (by_e + EW'(BALL_SIZE) > p1_e) && (by_e < p1_e + EW'(PADDLE_LENGTH));
    assign ov_two = (by_e + EW'(BALL_SIZE) > p2_e) && (by_e < p2_e + EW'(PADDLE_LENGTH));

    assign hit_one  = (bx_e <= EW'(PADDLE_ONE_X + PADDLE_WIDTH) + spd_e)
                   && (bx_e + EW'(BALL_SIZE) > EW'(PADDLE_ONE_X)) && ov_one;
    assign miss_one = (bx_e <= spd_e);
    assign hit_two  = (bx_e + EW'(BALL_SIZE) + spd_e >= EW'(PADDLE_TWO_X))
                   && (bx_e < EW'(PADDLE_TWO_X + PADDLE_WIDTH)) && ov_two;
    assign miss_two = (bx_e + EW'(BALL_SIZE) + spd_e >= EW'(SCREEN_W));

    assign top_hit = (by_e <= spd_e);
    assign bot_hit = (by_e + EW'(BALL_SIZE) + spd_e >= EW'(SCREEN_H));

    assign speed_inc = (speed == SPEED_TOP) ? speed : speed + SPEED_ONE;

    // Wall bounce clamps the ball flush against the wall instead of overshooting.
    always_comb begin
        y_mv  = ball_y;
        dy_mv = dir_y;
        if (!dir_y) begin
            if (top_hit) begin
                y_mv  = '0;
                dy_mv = 1'b1;
            end else begin
                y_mv = ball_y - POS_W'(speed);
            end
        end else begin
            if (bot_hit) begin
                y_mv  = POS_W'(SCREEN_H - BALL_SIZE);
                dy_mv = 1'b0;
            end else begin
                y_mv = ball_y + POS_W'(speed);
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bx_nx    = ball_x;
        by_nx    = ball_y;
        dx_nx    = dir_x;
        dy_nx    = dir_y;
        speed_nx = speed;
        s1_nx    = score_one;
        s2_nx    = score_two;
        col_nx   = 1'b0;
        mis_nx   = 1'b0;
        if (restart) begin
            state_nx = SERVE;
            cnt_nx   = '0;
            bx_nx    = CX;
            by_nx    = CY;
            dx_nx    = 1'b0;
            dy_nx    = 1'b1;
            speed_nx = SPEED_ONE;
            s1_nx    = '0;
            s2_nx    = '0;
        end else if (tick) begin
            case (state)
                SERVE: begin
                    bx_nx    = CX;
                    by_nx    = CY;
                    speed_nx = SPEED_ONE;
                    if (cnt == CNT_LAST) begin
                        state_nx = PLAY;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                PLAY: begin
                    by_nx = y_mv;
                    dy_nx = dy_mv;
                    if (!dir_x) begin
                        if (hit_one) begin
                            bx_nx    = POS_W'(PADDLE_ONE_X + PADDLE_WIDTH);
                            dx_nx    = 1'b1;
                            speed_nx = speed_inc;
                            col_nx   = 1'b1;
                        end else if (miss_one) begin
                            s2_nx  = score_two + 4'd1;
                            mis_nx = 1'b1;
                            dx_nx  = 1'b0;
                        end else begin
                            bx_nx = ball_x - POS_W'(speed);
                        end
                    end else begin
                        if (hit_two) begin
                            bx_nx    = POS_W'(PADDLE_TWO_X - BALL_SIZE);
                            dx_nx    = 1'b0;
                            speed_nx = speed_inc;
                            col_nx   = 1'b1;
                        end else if (miss_two) begin
                            s1_nx  = score_one + 4'd1;
                            mis_nx = 1'b1;
                            dx_nx  = 1'b1;
                        end else begin
                            bx_nx = ball_x + POS_W'(speed);
                        end
                    end
                    // A point recentres the ball; the vertical direction still follows the wall rule.
                    if (mis_nx) begin
                        bx_nx    = CX;
                        by_nx    = CY;
                        speed_nx = SPEED_ONE;
                        state_nx = (s1_nx == WIN || s2_nx == WIN) ? OVER : SERVE;
                    end
                end
                OVER: begin
                    bx_nx = CX;
                    by_nx = CY;
                end
                default: state_nx = SERVE;
            endcase
        end
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            state        <= SERVE;
            cnt          <= '0;
            ball_x       <= CX;
            ball_y       <= CY;
            dir_x        <= 1'b0;
            dir_y        <= 1'b1;
            speed        <= SPEED_ONE;
            score_one    <= '0;
            score_two    <= '0;
            collided     <= 1'b0;
            missed       <= 1'b0;
            endofframe_q <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            ball_x       <= bx_nx;
            ball_y       <= by_nx;
            dir_x        <= dx_nx;
            dir_y        <= dy_nx;
            speed        <= speed_nx;
            score_one    <= s1_nx;
            score_two    <= s2_nx;
            collided     <= col_nx;
            missed       <= mis_nx;
            endofframe_q <= endofframe;
        end
    end

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb/tb_pong_ball_engine.sv - randomized bench for pong_ball_engine against an integer behavioural model
module tb_pong_ball_engine;

    localparam int W = 640, H = 480, BS = 10, PL = 50, PW = 5;
    localparam int P1X = 20, P2X = 600, SMAX = 4, SD = 3, WIN = 9;
    localparam int CX = (W - BS) / 2, CY = (H - BS) / 2;

    logic       clk50M = 1'b0;
    logic       reset_n, endofframe, restart;
    logic [9:0] paddle_one_y, paddle_two_y;
    logic [9:0] ball_x, ball_y;
    logic [3:0] score_one, score_two;
    logic       collided, missed, game_over;

    pong_ball_engine #(.SERVE_DELAY(SD)) dut (
        .clk50M(clk50M), .reset_n(reset_n), .endofframe(endofframe), .restart(restart),
        .paddle_one_y(paddle_one_y), .paddle_two_y(paddle_two_y),
        .ball_x(ball_x), .ball_y(ball_y), .score_one(score_one), .score_two(score_two),
        .collided(collided), .missed(missed), .game_over(game_over)
    );

    always #10 clk50M = ~clk50M;

    int errors = 0, checks = 0;
    int m_mode, m_cnt, m_bx, m_by, m_dx, m_dy, m_spd, m_s1, m_s2, m_col, m_mis, m_eofq;
    int pmode = 0;
    int n_col = 0, n_mis = 0;
    bit chk_en = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_restart();
        m_mode = 0; m_cnt = 0; m_bx = CX; m_by = CY;
        m_dx = 0; m_dy = 1; m_spd = 1; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_reset();
        model_restart();
        m_col = 0; m_mis = 0; m_eofq = 0;
    endtask

    // Mode: 0 serving, 1 playing, 2 game over.
    task automatic model_step();
        bit tk;
        int s, p1, p2, ny, ndy;
        if (!reset_n) begin
            model_reset();
            return;
        end
        tk = endofframe && !m_eofq;
        m_eofq = int'(endofframe);
        m_col = 0; m_mis = 0;
        if (restart) begin
            model_restart();
            return;
        end
        if (!tk) return;
        if (m_mode == 0) begin
            m_bx = CX; m_by = CY; m_spd = 1;
            if (m_cnt == SD - 1) begin m_mode = 1; m_cnt = 0; end
            else m_cnt++;
        end else if (m_mode == 1) begin
            s = m_spd; p1 = int'(paddle_one_y); p2 = int'(paddle_two_y);
            ny = m_by; ndy = m_dy;
            if (m_dy == 0) begin
                if (m_by <= s) begin ny = 0; ndy = 1; end else ny = m_by - s;
            end else begin
                if (m_by + BS + s >= H) begin ny = H - BS; ndy = 0; end else ny = m_by + s;
            end
            if (m_dx == 0) begin
                if (m_bx <= P1X + PW + s && m_bx + BS > P1X && m_by + BS > p1 && m_by < p1 + PL) begin
                    m_bx = P1X + PW; m_dx = 1; m_spd = (s < SMAX) ? s + 1 : SMAX; m_col = 1;
                end else if (m_bx <= s) begin
                    m_s2++; m_mis = 1; m_dx = 0;
                end else m_bx = m_bx - s;
            end else begin
                if (m_bx + BS + s >= P2X && m_bx < P2X + PW && m_by + BS > p2 && m_by < p2 + PL) begin
                    m_bx = P2X - BS; m_dx = 0; m_spd = (s < SMAX) ? s + 1 : SMAX; m_col = 1;
                end else if (m_bx + BS + s >= W) begin
                    m_s1++; m_mis = 1; m_dx = 1;
                end else m_bx = m_bx + s;
            end
            m_by = ny; m_dy = ndy;
            if (m_mis) begin
                m_bx = CX; m_by = CY; m_spd = 1;
                m_mode = (m_s1 == WIN || m_s2 == WIN) ? 2 : 0;
            end
        end
    endtask

    function automatic int track(input int by);
        int p;
        p = by - int'($urandom_range(0, 40));
        if (p < 0) p = 0;
        if (p > 430) p = 430;
        return p;
    endfunction

    task automatic cyc(input bit eof, input bit rs, input bit rn);
        @(negedge clk50M);
        endofframe = eof; restart = rs; reset_n = rn;
        case (pmode)
            0: begin
                paddle_one_y = 10'($urandom_range(0, 430));
                paddle_two_y = 10'($urandom_range(0, 430));
            end
            1: begin
                paddle_one_y = 10'(track(m_by));
                paddle_two_y = 10'(track(m_by));
            end
            default: begin
                paddle_one_y = (m_by >= 240) ? 10'd0 : 10'd430;
                paddle_two_y = 10'(track(m_by));
            end
        endcase
        @(posedge clk50M);
        #1;
        model_step();
    endtask

    task automatic frame();
        repeat ($urandom_range(1, 2)) cyc(0, 0, 1);
        repeat ($urandom_range(1, 2)) cyc(1, 0, 1);
    endtask

    always @(negedge clk50M) begin
        if (chk_en) begin
            check("ball_x", int'(ball_x), m_bx);
            check("ball_y", int'(ball_y), m_by);
            check("score_one", int'(score_one), m_s1);
            check("score_two", int'(score_two), m_s2);
            check("collided", int'(collided), m_col);
            check("missed", int'(missed), m_mis);
            check("game_over", int'(game_over), (m_mode == 2) ? 1 : 0);
            if (collided === 1'b1) n_col++;
            if (missed === 1'b1) n_mis++;
        end
    end

    initial begin
        int n, hold_x, hold_y;
        reset_n = 0; endofframe = 0; restart = 0; paddle_one_y = 0; paddle_two_y = 0;
        model_reset();
        cyc(0, 0, 0);
        chk_en = 1;
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        check("reset_ball_x", int'(ball_x), 315);
        check("reset_ball_y", int'(ball_y), 235);
        check("reset_scores", int'({score_one, score_two}), 0);
        check("reset_game_over", int'(game_over), 0);

        // Serve delay of three ticks, then diagonal movement down-left.
        repeat (3) frame();
        check("serve_hold_x", int'(ball_x), 315);
        check("serve_hold_y", int'(ball_y), 235);
        frame();
        check("first_move_x", int'(ball_x), 314);
        check("first_move_y", int'(ball_y), 236);
        cyc(0, 0, 1);
        repeat (100) cyc(1, 0, 1);
        check("long_eof_x", int'(ball_x), 313);
        check("long_eof_y", int'(ball_y), 237);
        cyc(0, 0, 1);

        pmode = 1;
        repeat (400) frame();
        check("rally_hits_seen", (n_col > 0) ? 1 : 0, 1);

        pmode = 0;
        repeat (300) frame();

        // Restart, get into play, then drop reset between clock edges.
        cyc(0, 1, 1);
        repeat (6) frame();
        @(posedge clk50M);
        #3;
        reset_n = 0;
        #1;
        check("async_ball_x", int'(ball_x), 315);
        check("async_ball_y", int'(ball_y), 235);
        check("async_pulses", int'({collided, missed}), 0);
        check("async_game_over", int'(game_over), 0);
        model_reset();
        cyc(0, 0, 0);
        cyc(0, 0, 1);

        pmode = 2;
        n_mis = 0;
        n = 0;
        while (m_mode != 2 && n < 4000) begin
            frame();
            n++;
        end
        check("game_over_reached", int'(game_over), 1);
        check("final_score_two", int'(score_two), 9);
        check("final_score_one", int'(score_one), 0);
        check("miss_pulses", n_mis, 9);
        hold_x = int'(ball_x); hold_y = int'(ball_y);
        repeat (5) frame();
        check("over_hold_x", int'(ball_x), 315);
        check("over_hold_y", int'(ball_y), 235);
        cyc(0, 1, 1);
        check("restart_scores", int'({score_one, score_two}), 0);
        check("restart_game_over", int'(game_over), 0);
        pmode = 0;
        repeat (20) frame();

        chk_en = 0;
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pong_ball_engine.md
# pong_ball_engine

Parametrised ball physics and scoring engine for two-player Pong. It runs on `clk50M`, advances the ball once per video frame on the rising edge of `endofframe`, and bounces the ball off the top and bottom walls and both paddles. It detects misses, keeps both scores and runs the serve / play / game-over sequence. It sits between the joystick paddle-movement blocks and `graphics`, and replaces the single-paddle frame-clocked ball mover.

## Interface

Parameters:
- `SCREEN_W`, 640: active width in pixels.
- `SCREEN_H`, 480: active height in pixels.
- `POS_W`, 10: width of all position buses.
- `BALL_SIZE`, 10: ball edge length in pixels.
- `PADDLE_LENGTH`, 50: paddle height in pixels.
- `PADDLE_WIDTH`, 5: paddle thickness in pixels.
- `PADDLE_ONE_X`, 20: left paddle x of its left edge.
- `PADDLE_TWO_X`, 600: right paddle x of its left edge.
- `SPEED_MAX`, 4: maximum pixels per frame on each axis; must be ≥1.
- `SERVE_DELAY`, 60: number of frames the ball is held before each serve.
- `WIN_SCORE`, 9: score that ends the game; must be ≤15.

Ports:
- `clk50M`, input, 1: system clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `endofframe`, input, 1: level from VGA timing, synchronous to `clk50M`; its rising edge is the frame tick.
- `restart`, input, 1: one-cycle pulse that starts a new game.
- `paddle_one_y`, input, POS_W: top row of the left paddle.
- `paddle_two_y`, input, POS_W: top row of the right paddle.
- `ball_x`, output, POS_W: left column of the ball (registered).
- `ball_y`, output, POS_W: top row of the ball (registered).
- `score_one`, output, 4: left player score.
- `score_two`, output, 4: right player score.
- `collided`, output, 1: one-cycle pulse on a paddle hit.
- `missed`, output, 1: one-cycle pulse when a point is scored.
- `game_over`, output, 1: high in state OVER.

Clock and reset are fixed: one clock, `clk50M`; reset is asynchronous and active-low, `reset_n`.

## Operation

- **Frame tick.** `tick = endofframe & ~endofframe_q`, where `endofframe_q` is a register. All motion and state changes happen only on tick cycles, except `restart`.
- **Ball state.**
  - `dir_x`: 0 = left, 1 = right.
  - `dir_y`: 0 = up, 1 = down.
  - `speed`: 1..SPEED_MAX, applied to both axes.
- **Centre position.** CX = (SCREEN_W−BALL_SIZE)/2, CY = (SCREEN_H−BALL_SIZE)/2.
- **States:**
  - SERVE
    - Ball is held at (CX, CY) and `speed`=1.
    - Serve counter counts ticks; on the tick where the counter reaches SERVE_DELAY−1 → PLAY, counter cleared.
  - PLAY, on each tick, evaluated from the current registered values:
    - Vertical:
      - Moving up and `ball_y` ≤ speed → `ball_y`=0 and `dir_y`=1.
      - Moving down and `ball_y`+BALL_SIZE+speed ≥ SCREEN_H → `ball_y`=SCREEN_H−BALL_SIZE and `dir_y`=0.
      - Otherwise `ball_y` ± speed.
    - Vertical overlap for a paddle at y P: `ball_y`+BALL_SIZE > P and `ball_y` < P+PADDLE_LENGTH.
    - Horizontal, moving left, in priority order:
      1. `ball_x` ≤ PADDLE_ONE_X+PADDLE_WIDTH+speed, `ball_x`+BALL_SIZE > PADDLE_ONE_X, and overlap with `paddle_one_y` → hit. `ball_x`=PADDLE_ONE_X+PADDLE_WIDTH, `dir_x`=1, `speed` incremented and saturated at SPEED_MAX, `collided` pulsed.
      2. `ball_x` ≤ speed → miss. `score_two`+1, `missed` pulsed, `dir_x`=0 (next serve goes toward the left player, who lost the point).
      3. Otherwise `ball_x`−speed.
    - Horizontal, moving right: mirror of the above.
      - Hit test: `ball_x`+BALL_SIZE+speed ≥ PADDLE_TWO_X, `ball_x` < PADDLE_TWO_X+PADDLE_WIDTH, and overlap with `paddle_two_y`. On a hit, `ball_x`=PADDLE_TWO_X−BALL_SIZE and `dir_x`=0.
      - Miss test: `ball_x`+BALL_SIZE+speed ≥ SCREEN_W. On a miss, `score_one`+1 and `dir_x`=1.
    - The vertical and horizontal updates are independent and both apply on the same tick.
    - After a miss: if the new score equals WIN_SCORE → OVER, otherwise → SERVE. In both cases the ball is set to (CX, CY) and `speed`=1.
  - OVER
    - Ball is held at centre, scores are frozen, `game_over`=1.
    - Only `restart` or reset leaves this state.
- **restart.** In any state, `restart` has priority over the tick. On the next edge: scores=0, state=SERVE, serve counter=0, ball at centre, `speed`=1, `dir_x`=0, `dir_y`=1.
- **Paddle inputs** are sampled only on tick cycles.

## Timing

- **Reset values** (all asynchronous on `reset_n` low):
  - state=SERVE, counter=0.
  - `ball_x`=CX, `ball_y`=CY.
  - `dir_x`=0, `dir_y`=1, `speed`=1.
  - `score_one`=`score_two`=0.
  - `collided`=`missed`=0, `game_over`=0, `endofframe_q`=0.
- **Latency.** Outputs update on the `clk50M` edge following the cycle where `tick`=1. `collided` and `missed` are high for exactly that one cycle.
- **Long `endofframe`.** A level held high for N cycles produces one tick only.
- **Reset mid-PLAY.** Ball returns to centre immediately, with no output glitch after `reset_n` deasserts.
- **First serve.** The first ball movement happens on tick number SERVE_DELAY+1 after reset.

## Test plan

- **Serve delay.** Reset, SERVE_DELAY=3, 5 ticks → `ball_x`=315 and `ball_y`=235 through tick 3; tick 4 gives (314, 236); tick 5 gives (313, 237).
- **Top wall.** In PLAY, ball at y=1 moving up with speed 1 → next tick `ball_y`=0 and `dir_y`=1; the following tick `ball_y`=1.
- **Left paddle hit.** `paddle_one_y`=200, ball at (26, 210) moving left → `ball_x`=25, `collided` pulse of 1 cycle, `speed`=2, `dir_x`=1. Repeat 5 hits → `speed` holds at 4.
- **Miss scoring.** `paddle_one_y`=0, ball at (1, 300) moving left → `missed` pulse, `score_two`=1, ball at (315, 235), state SERVE.
- **Game over and restart.** Force 9 right-player misses → `game_over`=1 and ticks leave the ball unchanged. A `restart` pulse → scores 0, `game_over`=0, SERVE.
- **Async reset and tick edge.** Assert `reset_n`=0 mid-PLAY between clock edges → outputs equal the reset values immediately. Hold `endofframe` high for 100 cycles → the ball advances exactly once.
